// File: rtl/eight_to_three_serial_encoder.sv
// Serial 8-to-3 encoder: accepts one multi-hot vector and emits the index of each set bit,
// one per output handshake, lowest-first or highest-first depending on HIGH_FIRST.
module eight_to_three_serial_encoder #(
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_last,
  output logic [3:0] remaining,
  output logic       zero_err
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [3:0] remaining_q, remaining_d;
  logic       zero_err_q, zero_err_d;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Priority pick: the last matching write in the loop wins.
  always_comb begin
    out_code = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) out_code = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) out_code = 3'(i);
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StEmit);
  assign out_last  = out_valid && (remaining_q == 4'd1);
  assign remaining = remaining_q;
  assign zero_err  = zero_err_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    remaining_d = remaining_q;
    zero_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_vec != 8'h00) begin
            pending_d   = in_vec;
            remaining_d = popcount8(in_vec);
            state_d     = StEmit;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          pending_d   = pending_q & ~(8'b0000_0001 << out_code);
          remaining_d = remaining_q - 4'd1;
          if (out_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      remaining_q <= '0;
      zero_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      remaining_q <= remaining_d;
      zero_err_q  <= zero_err_d;
    end
  end

endmodule

// File: tb/tb_eight_to_three_serial_encoder.sv
// Bench for eight_to_three_serial_encoder: ascending and descending instances in lockstep,
// scoreboard queues filled on input handshakes and drained on output handshakes.
module tb_eight_to_three_serial_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = 8'h00;
  logic       out_ready = 1'b1;

  logic       in_ready_lo, out_valid_lo, out_last_lo, zero_err_lo;
  logic [2:0] out_code_lo;
  logic [3:0] remaining_lo;
  logic       in_ready_hi, out_valid_hi, out_last_hi, zero_err_hi;
  logic [2:0] out_code_hi;
  logic [3:0] remaining_hi;

  always #5 clk = ~clk;

  eight_to_three_serial_encoder #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_lo),
    .in_vec    (in_vec),
    .out_valid (out_valid_lo),
    .out_ready (out_ready),
    .out_code  (out_code_lo),
    .out_last  (out_last_lo),
    .remaining (remaining_lo),
    .zero_err  (zero_err_lo)
  );

  eight_to_three_serial_encoder #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_hi),
    .in_vec    (in_vec),
    .out_valid (out_valid_hi),
    .out_ready (out_ready),
    .out_code  (out_code_hi),
    .out_last  (out_last_hi),
    .remaining (remaining_hi),
    .zero_err  (zero_err_hi)
  );

  typedef struct {
    logic [2:0] code;
    logic       last;
    logic [3:0] rem;
  } exp_t;

  typedef struct {
    logic [7:0] vec;
    bit         stall;
    int         exp_n;
  } vec_t;

  exp_t q_lo[$];
  exp_t q_hi[$];
  int   log_lo[$];
  int   log_hi[$];
  int   checks = 0;
  int   failures = 0;
  int   hs_cnt = 0;
  int   acc_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(input logic [7:0] v);
    int   rem;
    exp_t e;
    rem = $countones(v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        e.code = 3'(i);
        e.rem  = 4'(rem);
        e.last = (rem == 1);
        q_lo.push_back(e);
        rem--;
      end
    end
    rem = $countones(v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        e.code = 3'(i);
        e.rem  = 4'(rem);
        e.last = (rem == 1);
        q_hi.push_back(e);
        rem--;
      end
    end
  endfunction

  // Monitor: sample in the low phase, when the driven inputs are settled for the next edge.
  bit         zexp = 1'b0;
  bit         zexp_next;
  bit         stall_v = 1'b0;
  logic [2:0] st_code;
  logic       st_last;
  logic [3:0] st_rem;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q_lo.delete();
      q_hi.delete();
      zexp    = 1'b0;
      stall_v = 1'b0;
    end else begin
      chk("ready_and_valid_lo", int'(in_ready_lo && out_valid_lo), 0);
      chk("ready_and_valid_hi", int'(in_ready_hi && out_valid_hi), 0);
      chk("rem_popcount_lo", int'(remaining_lo), $countones(dut_lo.pending_q));
      chk("rem_popcount_hi", int'(remaining_hi), $countones(dut_hi.pending_q));
      if (stall_v) begin
        chk("stall_valid_held", int'(out_valid_lo), 1);
        chk("stall_code_held", int'(out_code_lo), int'(st_code));
        chk("stall_last_held", int'(out_last_lo), int'(st_last));
        chk("stall_rem_held", int'(remaining_lo), int'(st_rem));
      end
      zexp_next = 1'b0;
      if (in_valid && in_ready_lo) begin
        acc_cnt++;
        if (in_vec == 8'h00) zexp_next = 1'b1;
        else push_exp(in_vec);
      end
      if (out_valid_lo && out_ready) begin
        hs_cnt++;
        if (q_lo.size() == 0 || q_hi.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q_lo.pop_front();
          chk("code_lo", int'(out_code_lo), int'(e.code));
          chk("last_lo", int'(out_last_lo), int'(e.last));
          chk("rem_lo", int'(remaining_lo), int'(e.rem));
          log_lo.push_back(int'(out_code_lo));
          e = q_hi.pop_front();
          chk("valid_hi", int'(out_valid_hi), 1);
          chk("code_hi", int'(out_code_hi), int'(e.code));
          chk("last_hi", int'(out_last_hi), int'(e.last));
          chk("rem_hi", int'(remaining_hi), int'(e.rem));
          log_hi.push_back(int'(out_code_hi));
        end
      end
      stall_v = out_valid_lo && !out_ready;
      st_code = out_code_lo;
      st_last = out_last_lo;
      st_rem  = remaining_lo;
      chk("zero_err_lo", int'(zero_err_lo), int'(zexp));
      chk("zero_err_hi", int'(zero_err_hi), int'(zexp));
      zexp = zexp_next;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_lo && n < 50) begin
      step();
      n++;
    end
    chk("ready_timeout", int'(in_ready_lo), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid_lo && n < 100) begin
      step();
      n++;
    end
    chk("drain_timeout", int'(out_valid_lo), 0);
  endtask

  task automatic run_vec(input logic [7:0] v, input bit stall, input int exp_n);
    int h0;
    int n;
    wait_ready();
    h0 = hs_cnt;
    in_vec    = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    if (v == 8'h00) begin
      chk("zero_pulse", int'(zero_err_lo), 1);
      chk("zero_no_valid", int'(out_valid_lo), 0);
      chk("zero_ready", int'(in_ready_lo), 1);
    end else begin
      chk("accept_valid", int'(out_valid_lo), 1);
      chk("accept_busy", int'(in_ready_lo), 0);
    end
    n = 1;
    while (out_valid_lo && n < 100) begin
      step();
      out_ready = stall ? (n % 3 == 0) : 1'b1;
      n++;
    end
    chk("emit_timeout", int'(out_valid_lo), 0);
    chk("handshakes", hs_cnt - h0, exp_n);
    out_ready = 1'b1;
  endtask

  vec_t tbl[7];

  initial begin
    int a0;
    tbl[0] = '{vec: 8'h01, stall: 1'b0, exp_n: 1};
    tbl[1] = '{vec: 8'hA6, stall: 1'b0, exp_n: 4};
    tbl[2] = '{vec: 8'hFF, stall: 1'b1, exp_n: 8};
    tbl[3] = '{vec: 8'h00, stall: 1'b0, exp_n: 0};
    tbl[4] = '{vec: 8'h3C, stall: 1'b1, exp_n: 4};
    tbl[5] = '{vec: 8'h80, stall: 1'b0, exp_n: 1};
    tbl[6] = '{vec: 8'h55, stall: 1'b1, exp_n: 4};

    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_in_ready", int'(in_ready_lo), 1);
    chk("rst_out_valid", int'(out_valid_lo), 0);
    chk("rst_out_code", int'(out_code_lo), 0);
    chk("rst_out_last", int'(out_last_lo), 0);
    chk("rst_remaining", int'(remaining_lo), 0);
    chk("rst_zero_err", int'(zero_err_lo), 0);

    // Single-bit vector: latency and bubble before the next acceptance.
    in_vec   = 8'h01;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_valid", int'(out_valid_lo), 1);
    chk("t1_code", int'(out_code_lo), 0);
    chk("t1_last", int'(out_last_lo), 1);
    chk("t1_rem", int'(remaining_lo), 1);
    step();
    chk("t1_idle_valid", int'(out_valid_lo), 0);
    chk("t1_idle_ready", int'(in_ready_lo), 1);

    log_lo.delete();
    log_hi.delete();
    run_vec(8'hA6, 1'b0, 4);
    chk("t2_len_lo", log_lo.size(), 4);
    chk("t2_len_hi", log_hi.size(), 4);
    if (log_lo.size() == 4 && log_hi.size() == 4) begin
      chk("t2_lo0", log_lo[0], 1);
      chk("t2_lo1", log_lo[1], 2);
      chk("t2_lo2", log_lo[2], 5);
      chk("t2_lo3", log_lo[3], 7);
      chk("t2_hi0", log_hi[0], 7);
      chk("t2_hi1", log_hi[1], 5);
      chk("t2_hi2", log_hi[2], 2);
      chk("t2_hi3", log_hi[3], 1);
    end

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i].vec, tbl[i].stall, tbl[i].exp_n);
    end

    // Reset in the middle of a vector.
    wait_ready();
    log_lo.delete();
    in_vec    = 8'h81;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5_first_code", int'(out_code_lo), 0);
    step();
    chk("t5_second_code", int'(out_code_lo), 7);
    reset     = 1'b1;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    chk("t5_rst_valid", int'(out_valid_lo), 0);
    chk("t5_rst_rem", int'(remaining_lo), 0);
    chk("t5_rst_ready", int'(in_ready_lo), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_quiet", int'(out_valid_lo), 0);
    end
    chk("t5_emitted", log_lo.size(), 1);
    log_lo.delete();
    run_vec(8'h10, 1'b0, 1);
    chk("t5_after_len", log_lo.size(), 1);
    if (log_lo.size() == 1) chk("t5_after_code", log_lo[0], 4);

    // in_valid held during EMIT must not be taken until IDLE.
    wait_ready();
    log_lo.delete();
    a0        = acc_cnt;
    in_vec    = 8'h03;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_vec = 8'h08;
    for (int n = 0; n < 20 && acc_cnt < a0 + 2; n++) begin
      step();
    end
    in_valid = 1'b0;
    chk("t6_accepts", acc_cnt - a0, 2);
    drain();
    chk("t6_len", log_lo.size(), 3);
    if (log_lo.size() == 3) begin
      chk("t6_c0", log_lo[0], 0);
      chk("t6_c1", log_lo[1], 1);
      chk("t6_c2", log_lo[2], 3);
    end

    step();
    step();
    chk("sb_empty_lo", q_lo.size(), 0);
    chk("sb_empty_hi", q_hi.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
